// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Command sequencer that sits between a command source and a purely
// combinational 16-bit ALU. Commands name registers in a small internal
// register file; the sequencer reads operands, drives the ALU, iterates the
// ALU's single-bit shifts into N-bit shifts, writes the result back and
// signals completion with a one-cycle response pulse.
//
// Ports
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   cmd_valid     : command offered
//   cmd_ready     : high only while idle; a command is taken on valid&ready
//   cmd_ld        : 1 = load cmd_imm into R[cmd_dst], 0 = ALU operation
//   cmd_op        : ALU mode 0-15 (0-3 are the single-bit shifts)
//   cmd_dst       : destination register
//   cmd_srca/srcb : A / B operand registers
//   cmd_cin       : carry-in used by modes 4/5
//   cmd_cnt       : shift count for modes 0-3
//   cmd_imm       : immediate value for loads
//   alu_a/b/cin/mode : ALU operand and mode drive, all zero outside EXEC
//   alu_y, alu_ovf   : ALU result and overflow
//   rsp_valid     : one-cycle pulse while the write-back happens
//   rsp_data      : value written back, held until the next write-back
//   rsp_ovf       : overflow of the last op, forced 0 unless mode 4/5
//   dbg_sel       : debug register select
//   dbg_data      : R[dbg_sel], combinational

module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int AW    = 2,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic             cmd_cin,
  input  logic [CW-1:0]    cmd_cnt,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_mode,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regFile_q [NREG];
  logic [WIDTH-1:0] regFile_d [NREG];
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [CW-1:0]    iter_q, iter_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic             cin_q, cin_d;
  logic             ld_q, ld_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rspData_q, rspData_d;
  logic             rspOvf_q, rspOvf_d;

  logic             cmdIsShift;
  logic             arithOp;
  logic             ovfReport;

  // Modes 0-3 are the ALU's single-bit shifts; only they use the count.
  assign cmdIsShift = (cmd_op[3:2] == 2'b00);

  // The ALU keeps a stale Overflow for non-arithmetic modes, so only an
  // add/subtract (and never a load) is allowed to report it.
  assign arithOp   = !ld_q && ((op_q == 4'd4) || (op_q == 4'd5));
  assign ovfReport = arithOp & ovf_q;

  // Next-state logic: accept in IDLE, iterate the ALU in EXEC, commit in WRITE.
  // Operands are captured at accept, so a command may name its own
  // destination as a source.
  always_comb begin
    state_d   = state_q;
    regFile_d = regFile_q;
    acc_d     = acc_q;
    opB_d     = opB_q;
    iter_d    = iter_q;
    op_d      = op_q;
    dst_d     = dst_q;
    cin_d     = cin_q;
    ld_d      = ld_q;
    ovf_d     = ovf_q;
    rspData_d = rspData_q;
    rspOvf_d  = rspOvf_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          opB_d = regFile_q[cmd_srcb];
          cin_d = cmd_cin;
          ld_d  = cmd_ld;
          ovf_d = 1'b0;
          if (cmd_ld) begin
            acc_d   = cmd_imm;
            state_d = WRITE;
          end else if (cmdIsShift && (cmd_cnt == '0)) begin
            acc_d   = regFile_q[cmd_srca];
            state_d = WRITE;
          end else begin
            acc_d   = regFile_q[cmd_srca];
            iter_d  = cmdIsShift ? cmd_cnt : CW'(1);
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        acc_d  = alu_y;
        ovf_d  = alu_ovf;
        iter_d = iter_q - CW'(1);
        if (iter_q == CW'(1)) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        regFile_d[dst_q] = acc_q;
        rspData_d        = acc_q;
        rspOvf_d         = ovfReport;
        state_d          = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= '0;
      end
      acc_q     <= '0;
      opB_q     <= '0;
      iter_q    <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      cin_q     <= 1'b0;
      ld_q      <= 1'b0;
      ovf_q     <= 1'b0;
      rspData_q <= '0;
      rspOvf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      regFile_q <= regFile_d;
      acc_q     <= acc_d;
      opB_q     <= opB_d;
      iter_q    <= iter_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      cin_q     <= cin_d;
      ld_q      <= ld_d;
      ovf_q     <= ovf_d;
      rspData_q <= rspData_d;
      rspOvf_q  <= rspOvf_d;
    end
  end

  // Output decode. During WRITE the response shows the value being written
  // so it is valid alongside rsp_valid; afterwards the captured copy holds it.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == WRITE);
    rsp_data  = (state_q == WRITE) ? acc_q : rspData_q;
    rsp_ovf   = (state_q == WRITE) ? ovfReport : rspOvf_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    alu_mode  = 4'd0;
    if (state_q == EXEC) begin
      alu_a    = acc_q;
      alu_b    = opB_q;
      alu_cin  = cin_q;
      alu_mode = op_q;
    end
  end

  assign dbg_data = regFile_q[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl. A behavioural combinational ALU is
// attached to the ALU port group; expected results come from a reference
// model that applies each command's whole effect at once (full N-bit shifts,
// integer add/subtract with range-based overflow) to a model register file.

module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdLd;
  logic [3:0]  cmdOp;
  logic [1:0]  cmdDst;
  logic [1:0]  cmdSrcA;
  logic [1:0]  cmdSrcB;
  logic        cmdCin;
  logic [3:0]  cmdCnt;
  logic [15:0] cmdImm;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic        aluCin;
  logic [3:0]  aluMode;
  logic [15:0] aluY;
  logic        aluOvf;
  logic        rspValid;
  logic [15:0] rspData;
  logic        rspOvf;
  logic [1:0]  dbgSel;
  logic [15:0] dbgData;

  int checks;
  int failures;

  logic [15:0] mdl [4];

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_ld    (cmdLd),
    .cmd_op    (cmdOp),
    .cmd_dst   (cmdDst),
    .cmd_srca  (cmdSrcA),
    .cmd_srcb  (cmdSrcB),
    .cmd_cin   (cmdCin),
    .cmd_cnt   (cmdCnt),
    .cmd_imm   (cmdImm),
    .alu_a     (aluA),
    .alu_b     (aluB),
    .alu_cin   (aluCin),
    .alu_mode  (aluMode),
    .alu_y     (aluY),
    .alu_ovf   (aluOvf),
    .rsp_valid (rspValid),
    .rsp_data  (rspData),
    .rsp_ovf   (rspOvf),
    .dbg_sel   (dbgSel),
    .dbg_data  (dbgData)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural ALU: one-bit shifts for modes 0-3, add/sub with carry-in,
  // logic ops elsewhere. Non-arithmetic modes present a stale Overflow of 1
  // so the controller's masking is exercised.
  always_comb begin
    logic [15:0] sum;
    sum    = '0;
    aluY   = '0;
    aluOvf = 1'b1;
    case (aluMode)
      4'd0: aluY = {aluA[14:0], 1'b0};
      4'd1: aluY = {aluA[14:0], aluA[15]};
      4'd2: aluY = {1'b0, aluA[15:1]};
      4'd3: aluY = {aluA[15], aluA[15:1]};
      4'd4: begin
        sum    = aluA + aluB + {15'd0, aluCin};
        aluY   = sum;
        aluOvf = (aluA[15] == aluB[15]) && (sum[15] != aluA[15]);
      end
      4'd5: begin
        sum    = aluA - aluB - {15'd0, aluCin};
        aluY   = sum;
        aluOvf = (aluA[15] != aluB[15]) && (sum[15] != aluA[15]);
      end
      4'd6:  aluY = aluA & aluB;
      4'd7:  aluY = aluA | aluB;
      4'd8:  aluY = aluA ^ aluB;
      4'd9:  aluY = ~aluA;
      4'd10: aluY = aluB;
      4'd11: aluY = aluA;
      4'd12: aluY = ~(aluA & aluB);
      4'd13: aluY = ~(aluA | aluB);
      4'd14: aluY = aluA & ~aluB;
      default: aluY = aluA & aluB;
    endcase
  end

  // Whole-command reference: result, reported overflow and EXEC cycle count.
  function automatic void refModel(input logic ld, input logic [3:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic [3:0] cnt,
                                   input logic [15:0] imm,
                                   output logic [15:0] y, output logic ovf,
                                   output int e);
    int sa;
    int sb;
    int s;
    int n;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    n   = int'(cnt);
    s   = 0;
    y   = '0;
    ovf = 1'b0;
    e   = 0;
    if (ld) begin
      y = imm;
    end else if (op < 4'd4) begin
      e = n;
      case (op)
        4'd0: y = a << n;
        4'd1: y = (n == 0) ? a : ((a << n) | (a >> (16 - n)));
        4'd2: y = a >> n;
        default: y = $signed(a) >>> n;
      endcase
    end else begin
      e = 1;
      case (op)
        4'd4: begin
          s   = sa + sb + int'(cin);
          y   = s[15:0];
          ovf = (s > 32767) || (s < -32768);
        end
        4'd5: begin
          s   = sa - sb - int'(cin);
          y   = s[15:0];
          ovf = (s > 32767) || (s < -32768);
        end
        4'd6:  y = a & b;
        4'd7:  y = a | b;
        4'd8:  y = a ^ b;
        4'd9:  y = ~a;
        4'd10: y = b;
        4'd11: y = a;
        4'd12: y = ~(a & b);
        4'd13: y = ~(a | b);
        4'd14: y = a & ~b;
        default: y = a & b;
      endcase
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllRegs(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbgSel = 2'(r);
      #1;
      checkOutput(tag, dbgData, mdl[r]);
    end
  endtask

  // Issues one command, follows it through EXEC to the response pulse and
  // checks timing, ALU drive, response and write-back.
  task automatic applyStimulus(input logic ld, input logic [3:0] op,
                               input logic [1:0] dst, input logic [1:0] srcA,
                               input logic [1:0] srcB, input logic cin,
                               input logic [3:0] cnt, input logic [15:0] imm);
    logic [15:0] expY;
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expOvf;
    int          expE;
    int          execSeen;
    bit          execOk;
    bit          gotRsp;
    int          waitN;

    waitN = 0;
    @(negedge clk);
    while (!cmdReady && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("ready_before_cmd", cmdReady, 1);

    cmdLd    = ld;
    cmdOp    = op;
    cmdDst   = dst;
    cmdSrcA  = srcA;
    cmdSrcB  = srcB;
    cmdCin   = cin;
    cmdCnt   = cnt;
    cmdImm   = imm;
    cmdValid = 1'b1;
    expA     = mdl[srcA];
    expB     = mdl[srcB];
    refModel(ld, op, expA, expB, cin, cnt, imm, expY, expOvf, expE);

    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdLd    = 1'($urandom);
    cmdOp    = 4'($urandom);
    cmdDst   = 2'($urandom);
    cmdSrcA  = 2'($urandom);
    cmdSrcB  = 2'($urandom);
    cmdCin   = 1'($urandom);
    cmdCnt   = 4'($urandom);
    cmdImm   = 16'($urandom);

    execSeen = 0;
    execOk   = 1'b1;
    gotRsp   = 1'b0;
    for (int c = 0; c < 40 && !gotRsp; c++) begin
      @(negedge clk);
      if (rspValid) begin
        gotRsp = 1'b1;
      end else begin
        if (execSeen == 0) begin
          checkOutput("alu_a_exec", aluA, expA);
          checkOutput("alu_b_exec", aluB, expB);
          checkOutput("alu_cin_exec", aluCin, cin);
        end
        if (aluMode !== op || cmdReady !== 1'b0) execOk = 1'b0;
        execSeen++;
      end
    end
    checkOutput("rsp_seen", gotRsp, 1);
    checkOutput("exec_cycles", execSeen, expE);
    if (expE > 0) checkOutput("alu_mode_exec", execOk, 1);
    checkOutput("rsp_data", rspData, expY);
    checkOutput("rsp_ovf", rspOvf, expOvf);
    checkOutput("alu_zero_in_write", {aluA, aluB, aluCin, aluMode} == '0, 1);
    mdl[dst] = expY;

    @(negedge clk);
    checkOutput("rsp_pulse_end", rspValid, 0);
    checkOutput("ready_after_rsp", cmdReady, 1);
    checkOutput("rsp_data_held", rspData, expY);
    dbgSel = dst;
    #1;
    checkOutput("dbg_dst", dbgData, mdl[dst]);
  endtask

  initial begin
    logic [15:0] expQ [$];
    logic [15:0] y;
    logic        o;
    int          e;
    int          issued;
    int          received;
    int          extra;
    bit          inOrder;

    checks   = 0;
    failures = 0;
    for (int r = 0; r < 4; r++) mdl[r] = '0;
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdLd    = 1'b0;
    cmdOp    = 4'd0;
    cmdDst   = 2'd0;
    cmdSrcA  = 2'd0;
    cmdSrcB  = 2'd0;
    cmdCin   = 1'b0;
    cmdCnt   = 4'd0;
    cmdImm   = 16'd0;
    dbgSel   = 2'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_rsp_valid", rspValid, 0);
    checkOutput("reset_rsp_data", rspData, 0);
    checkOutput("reset_rsp_ovf", rspOvf, 0);
    checkOutput("reset_alu_drive", {aluA, aluB, aluCin, aluMode}, 0);
    checkOutput("reset_cmd_ready", cmdReady, 1);
    checkAllRegs("reset_regs");
    rst = 1'b0;

    // Signed overflow on add.
    applyStimulus(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd0, 16'h7FFF);
    applyStimulus(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd0, 16'h0001);
    applyStimulus(1'b0, 4'd4, 2'd3, 2'd1, 2'd2, 1'b0, 4'd0, 16'h0000);

    // Iterated arithmetic and logical right shifts.
    applyStimulus(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 16'h8001);
    applyStimulus(1'b0, 4'd3, 2'd1, 2'd0, 2'd0, 1'b0, 4'd4, 16'h0000);
    applyStimulus(1'b0, 4'd2, 2'd1, 2'd0, 2'd0, 1'b0, 4'd4, 16'h0000);

    // Shift by zero is a pass-through straight to write-back.
    applyStimulus(1'b0, 4'd0, 2'd3, 2'd2, 2'd0, 1'b0, 4'd0, 16'h0000);

    // Source equals destination, then a non-arithmetic op with stale Overflow.
    applyStimulus(1'b0, 4'd5, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0, 16'h0000);
    applyStimulus(1'b0, 4'd15, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0, 16'h0000);

    // Randomized commands against the model.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 4'($urandom), 2'($urandom),
                    2'($urandom), 2'($urandom), 1'($urandom),
                    4'($urandom), 16'($urandom));
    end
    checkAllRegs("regs_after_random");

    // cmd_valid held high: one accept per ready cycle, in-order responses.
    issued   = 0;
    received = 0;
    inOrder  = 1'b1;
    for (int c = 0; c < 400 && received < 8; c++) begin
      @(negedge clk);
      if (rspValid) begin
        if (expQ.size() > 0) begin
          if (rspData !== expQ.pop_front()) inOrder = 1'b0;
        end else begin
          inOrder = 1'b0;
        end
        received++;
      end
      if (cmdReady) begin
        if (issued < 8) begin
          cmdLd   = ($urandom_range(0, 2) == 0);
          cmdOp   = 4'($urandom);
          cmdDst  = 2'($urandom);
          cmdSrcA = 2'($urandom);
          cmdSrcB = 2'($urandom);
          cmdCin  = 1'($urandom);
          cmdCnt  = 4'($urandom_range(0, 3));
          cmdImm  = 16'($urandom);
          refModel(cmdLd, cmdOp, mdl[cmdSrcA], mdl[cmdSrcB], cmdCin, cmdCnt,
                   cmdImm, y, o, e);
          mdl[cmdDst] = y;
          expQ.push_back(y);
          cmdValid = 1'b1;
          issued++;
        end else begin
          cmdValid = 1'b0;
        end
      end
    end
    cmdValid = 1'b0;
    checkOutput("hold_rsp_order", inOrder, 1);
    checkOutput("hold_rsp_count", received, 8);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (rspValid) extra++;
    end
    checkOutput("hold_no_extra_rsp", extra, 0);
    checkAllRegs("regs_after_hold");

    // Reset in the middle of a long shift aborts it.
    @(negedge clk);
    cmdLd    = 1'b0;
    cmdOp    = 4'd1;
    cmdDst   = 2'd2;
    cmdSrcA  = 2'd0;
    cmdSrcB  = 2'd0;
    cmdCin   = 1'b0;
    cmdCnt   = 4'd10;
    cmdValid = 1'b1;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_exec_mode", aluMode, 1);
    rst = 1'b1;
    #1;
    checkOutput("midexec_rsp_valid", rspValid, 0);
    checkOutput("midexec_cmd_ready", cmdReady, 1);
    checkOutput("midexec_alu_mode", aluMode, 0);
    checkOutput("midexec_rsp_data", rspData, 0);
    for (int r = 0; r < 4; r++) mdl[r] = '0;
    checkAllRegs("midexec_regs");
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (rspValid) extra++;
    end
    checkOutput("post_reset_no_rsp", extra, 0);
    checkAllRegs("post_reset_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
